// File: rtl/st_chan_adapt_pkg.sv
// Shared types for the Avalon-ST channel adapter: packet FSM states and the
// saturating drop-counter helper.
package st_chan_adapt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry (main + spare) registered skid stage; in_ready comes straight from a
// flop and is low while reset is held.
module st_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             spare_valid_q, spare_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] spare_q, spare_d;
    logic             push;

    always_comb begin
        push          = in_valid && in_ready_q;
        main_valid_d  = main_valid_q;
        main_d        = main_q;
        spare_valid_d = spare_valid_q;
        spare_d       = spare_q;
        if (!main_valid_q || out_ready) begin
            // Spare drains first; no push can coincide since in_ready is low then.
            if (spare_valid_q) begin
                main_valid_d  = 1'b1;
                main_d        = spare_q;
                spare_valid_d = 1'b0;
            end else begin
                main_valid_d = push;
                if (push) main_d = in_data;
            end
        end else if (push) begin
            spare_valid_d = 1'b1;
            spare_d       = in_data;
        end
        in_ready_d = !spare_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q  <= 1'b0;
            spare_valid_q <= 1'b0;
            in_ready_q    <= 1'b0;
            main_q        <= '0;
            spare_q       <= '0;
        end else begin
            main_valid_q  <= main_valid_d;
            spare_valid_q <= spare_valid_d;
            in_ready_q    <= in_ready_d;
            main_q        <= main_d;
            spare_q       <= spare_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/avalon_st_channel_adapter.sv
// Avalon-ST channel adapter: latches the channel at SOP, drops illegal-channel packets,
// re-bases the channel by CHAN_OFFSET. Define ST_CHAN_ADAPT_DROP_CNT_EN for drop_count.
module avalon_st_channel_adapter
    import st_chan_adapt_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IN_CHAN_W   = 1,
    parameter int OUT_CHAN_W  = 8,
    parameter int MAX_CHANNEL = 1,
    parameter int CHAN_OFFSET = 0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    output logic                                    in_ready,
    input  logic                                    in_valid,
    input  logic [DATA_W-1:0]                       in_data,
    input  logic                                    in_startofpacket,
    input  logic                                    in_endofpacket,
    // One dummy bit when IN_CHAN_W=0; it is ignored.
    input  logic [((IN_CHAN_W > 0) ? IN_CHAN_W : 1)-1:0] in_channel,
    input  logic                                    out_ready,
    output logic                                    out_valid,
    output logic [DATA_W-1:0]                       out_data,
    output logic                                    out_startofpacket,
    output logic                                    out_endofpacket,
    output logic [OUT_CHAN_W-1:0]                   out_channel,
    output logic                                    drop_pulse,
    output logic                                    proto_err
`ifdef ST_CHAN_ADAPT_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]                   drop_count
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic                  sop;
        logic                  eop;
        logic [OUT_CHAN_W-1:0] channel;
    } beat_t;

    if (longint'(MAX_CHANNEL) + longint'(CHAN_OFFSET) > (longint'(1) << OUT_CHAN_W) - longint'(1)) begin : g_err_out_w
        $error("MAX_CHANNEL + CHAN_OFFSET does not fit in OUT_CHAN_W");
    end
    if (IN_CHAN_W > 0 && longint'(MAX_CHANNEL) > (longint'(1) << IN_CHAN_W) - longint'(1)) begin : g_err_in_w
        $error("MAX_CHANNEL does not fit in IN_CHAN_W");
    end

    state_t                state_q, state_d;
    logic [OUT_CHAN_W-1:0] chan_q, chan_d, in_ch;
    logic                  ch_legal, acc, fwd, skid_in_ready;
    logic                  drop_pulse_q, drop_pulse_d, proto_err_q, proto_err_d;
    beat_t                 fwd_beat, out_beat;

    if (IN_CHAN_W > 0) begin : g_ch
        assign in_ch    = OUT_CHAN_W'(in_channel);
        assign ch_legal = 32'(in_channel) <= 32'(MAX_CHANNEL);
    end else begin : g_no_ch
        assign in_ch    = '0;
        assign ch_legal = 1'b1;
    end

    assign acc = in_valid && skid_in_ready;

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        fwd          = 1'b0;
        drop_pulse_d = 1'b0;
        proto_err_d  = 1'b0;
        if (acc) begin
            if (in_startofpacket) begin
                // A SOP always opens a new packet; an unterminated one is just flagged.
                proto_err_d = (state_q != IDLE);
                if (ch_legal) begin
                    chan_d  = in_ch;
                    fwd     = 1'b1;
                    state_d = in_endofpacket ? IDLE : PASS;
                end else begin
                    drop_pulse_d = 1'b1;
                    state_d      = in_endofpacket ? IDLE : DROP;
                end
            end else begin
                case (state_q)
                    PASS: begin
                        fwd = 1'b1;
                        if (in_endofpacket) state_d = IDLE;
                    end
                    DROP: if (in_endofpacket) state_d = IDLE;
                    default: proto_err_d = 1'b1;
                endcase
            end
        end
        fwd_beat.data    = in_data;
        fwd_beat.sop     = in_startofpacket;
        fwd_beat.eop     = in_endofpacket;
        fwd_beat.channel = chan_d + OUT_CHAN_W'(CHAN_OFFSET);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            chan_q       <= '0;
            drop_pulse_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            drop_pulse_q <= drop_pulse_d;
            proto_err_q  <= proto_err_d;
        end
    end

    st_skid_buffer #(.WIDTH($bits(beat_t))) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (fwd),
        .in_ready (skid_in_ready),
        .in_data  (fwd_beat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_beat)
    );

    assign in_ready          = skid_in_ready;
    assign out_data          = out_beat.data;
    assign out_startofpacket = out_beat.sop;
    assign out_endofpacket   = out_beat.eop;
    assign out_channel       = out_beat.channel;
    assign drop_pulse        = drop_pulse_q;
    assign proto_err         = proto_err_q;

`ifdef ST_CHAN_ADAPT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb drop_cnt_d = drop_pulse_d ? sat_inc(drop_cnt_q) : drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
